// File: rtl/emmc_ddr_data_tx.sv
// eMMC DDR write-data transmitter: start bit, N data words, per-line/per-edge CRC16, end bit.
// All outputs are registered except in_ready, which is decoded from the current state.
module emmc_ddr_data_tx (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  blk_words,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  d1_wire,
  output logic [7:0]  d2_wire,
  output logic        oe,
  output logic        busy,
  output logic        done,
  output logic        underrun
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StCrc, StEnd} state_e;

  state_e      state_q, state_d;
  logic [8:0]  n_q, n_d;
  logic [8:0]  acc_q, acc_d;
  logic [3:0]  j_q, j_d;
  logic [15:0] rcrc_q [8];
  logic [15:0] rcrc_d [8];
  logic [15:0] fcrc_q [8];
  logic [15:0] fcrc_d [8];
  logic [7:0]  d1_q, d1_d, d2_q, d2_d;
  logic        oe_q, oe_d, busy_q, busy_d, done_q, done_d, underrun_q, underrun_d;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // Words are accepted from the START cycle until all N have been taken.
  assign in_ready = (state_q == StStart) || ((state_q == StData) && (acc_q != n_q));

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    acc_d      = acc_q;
    j_d        = j_q;
    rcrc_d     = rcrc_q;
    fcrc_d     = fcrc_q;
    d1_d       = 8'hFF;
    d2_d       = 8'hFF;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StStart;
          n_d     = (blk_words == 8'd0) ? 9'd256 : {1'b0, blk_words};
          acc_d   = 9'd0;
          for (int i = 0; i < 8; i++) begin
            rcrc_d[i] = 16'h0000;
            fcrc_d[i] = 16'h0000;
          end
          d1_d = 8'h00;
          d2_d = 8'h00;
        end
      end
      StStart, StData: begin
        if (in_ready) begin
          if (!in_valid) begin
            state_d    = StIdle;
            underrun_d = 1'b1;
          end else begin
            state_d = StData;
            acc_d   = acc_q + 9'd1;
            d1_d    = in_data[7:0];
            d2_d    = in_data[15:8];
            for (int i = 0; i < 8; i++) begin
              rcrc_d[i] = crc16_step(rcrc_q[i], in_data[i]);
              fcrc_d[i] = crc16_step(fcrc_q[i], in_data[i+8]);
            end
          end
        end else begin
          state_d = StCrc;
          j_d     = 4'd0;
          for (int i = 0; i < 8; i++) begin
            d1_d[i] = rcrc_q[i][15];
            d2_d[i] = fcrc_q[i][15];
          end
        end
      end
      StCrc: begin
        // Registers shift left each CRC cycle so the next bit is always at [14].
        for (int i = 0; i < 8; i++) begin
          rcrc_d[i] = {rcrc_q[i][14:0], 1'b0};
          fcrc_d[i] = {fcrc_q[i][14:0], 1'b0};
        end
        if (j_q == 4'd15) begin
          state_d = StEnd;
        end else begin
          j_d = j_q + 4'd1;
          for (int i = 0; i < 8; i++) begin
            d1_d[i] = rcrc_q[i][14];
            d2_d[i] = fcrc_q[i][14];
          end
        end
      end
      StEnd: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    oe_d   = (state_d != StIdle);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      n_q        <= 9'd0;
      acc_q      <= 9'd0;
      j_q        <= 4'd0;
      d1_q       <= 8'hFF;
      d2_q       <= 8'hFF;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        rcrc_q[i] <= 16'h0000;
        fcrc_q[i] <= 16'h0000;
      end
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      acc_q      <= acc_d;
      j_q        <= j_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      for (int i = 0; i < 8; i++) begin
        rcrc_q[i] <= rcrc_d[i];
        fcrc_q[i] <= fcrc_d[i];
      end
    end
  end

  assign d1_wire  = d1_q;
  assign d2_wire  = d2_q;
  assign oe       = oe_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_emmc_ddr_data_tx.sv
// Directed bench for emmc_ddr_data_tx: frame timing, data order, CRC, underrun, reset, start rules.
module tb_emmc_ddr_data_tx;

  logic        clock = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  blk_words;
  logic [15:0] in_data;
  logic        in_ready, oe, busy, done, underrun;
  logic [7:0]  d1_wire, d2_wire;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int oe_cnt, rdy_cnt, data_err, crc_err, frame_bad, early_flag;
  logic [15:0] cap_r [8];
  logic [15:0] cap_f [8];
  logic [15:0] exp_r [8];
  logic [15:0] exp_f [8];

  emmc_ddr_data_tx dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .blk_words (blk_words),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d1_wire   (d1_wire),
    .d2_wire   (d2_wire),
    .oe        (oe),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] word(input logic [15:0] b, input int i);
    return b + 16'(i) * 16'h0103;
  endfunction

  // Serial CRC16-CCITT written out tap by tap.
  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    logic        fb;
    logic [15:0] n;
    fb = c[15] ^ b;
    for (int t = 1; t < 16; t++) n[t] = c[t-1];
    n[0]  = fb;
    n[5]  = c[4] ^ fb;
    n[12] = c[11] ^ fb;
    return n;
  endfunction

  task automatic kick(input int n);
    blk_words = n[7:0];
    start     = 1'b1;
    in_valid  = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Walks one frame from k=0 until oe falls; drives words while in_ready.
  task automatic observe(input int nn, input logic [15:0] base, input int poke);
    int k;
    logic [15:0] w;
    oe_cnt = 0; rdy_cnt = 0; data_err = 0; crc_err = 0; frame_bad = 0; early_flag = 0;
    for (int i = 0; i < 8; i++) begin
      cap_r[i] = '0; cap_f[i] = '0; exp_r[i] = '0; exp_f[i] = '0;
    end
    k = 0;
    while (oe === 1'b1 && k < 400) begin
      oe_cnt++;
      if (in_ready === 1'b1) rdy_cnt++;
      if (k == 0 && {d2_wire, d1_wire} !== 16'h0000) frame_bad++;
      if (k >= 1 && k <= nn) begin
        w = word(base, k - 1);
        if ({d2_wire, d1_wire} !== w) data_err++;
        for (int i = 0; i < 8; i++) begin
          exp_r[i] = crc_bit(exp_r[i], w[i]);
          exp_f[i] = crc_bit(exp_f[i], w[i+8]);
        end
      end
      if (k > nn && k <= nn + 16) begin
        for (int i = 0; i < 8; i++) begin
          cap_r[i] = {cap_r[i][14:0], d1_wire[i]};
          cap_f[i] = {cap_f[i][14:0], d2_wire[i]};
        end
      end
      if (k == nn + 17 && {d2_wire, d1_wire} !== 16'hFFFF) frame_bad++;
      if (done !== 1'b0 || underrun !== 1'b0 || busy !== 1'b1) early_flag++;
      start = (k == poke);
      if (k == poke) blk_words = 8'd3;
      in_data  = (k < nn) ? word(base, k) : 16'h0000;
      in_valid = 1'b1;
      tick();
      k++;
    end
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (cap_r[i] !== exp_r[i] || cap_f[i] !== exp_f[i]) crc_err++;
    end
  endtask

  task automatic check_block(input string tag, input int nn);
    check({tag, "_oe_cycles"}, oe_cnt, nn + 18);
    check({tag, "_ready_cycles"}, rdy_cnt, nn);
    check({tag, "_data_errs"}, data_err, 0);
    check({tag, "_crc_errs"}, crc_err, 0);
    check({tag, "_frame_bad"}, frame_bad, 0);
    check({tag, "_early_flags"}, early_flag, 0);
    check({tag, "_done_cycle"}, {d1_wire, d2_wire, oe, busy, done, underrun, in_ready},
          {16'hFFFF, 5'b00100});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; blk_words = 8'd0; in_data = 16'h0000;
    tick(); tick(); tick();
    check("reset_state", {d1_wire, d2_wire, oe, busy, done, underrun, in_ready},
          {16'hFFFF, 5'b00000});
    reset = 1'b0;
    tick();
    check("idle_after_reset", {d1_wire, d2_wire, oe, busy, in_ready}, {16'hFFFF, 3'b000});

    // One zero word: 19 oe cycles, all-zero CRC.
    kick(1);
    check("b1_start_ready", {in_ready, busy}, 2'b11);
    observe(1, 16'h0000, -1);
    check_block("b1", 1);
    check("b1_crc_zero", {cap_r[0], cap_f[7]}, 32'h0);
    tick();
    check("b1_done_one_cycle", {done, underrun}, 2'b00);

    // Underrun on the third in_ready cycle of a 4-word block.
    kick(4);
    in_data = 16'hBEEF; in_valid = 1'b1; tick();
    in_data = 16'h1357; in_valid = 1'b1; tick();
    check("ur_ready_k2", in_ready, 1'b1);
    in_valid = 1'b0; tick();
    check("ur_pulse", {d1_wire, d2_wire, oe, busy, done, underrun, in_ready},
          {16'hFFFF, 5'b00010});
    in_valid = 1'b1; tick();
    check("ur_one_cycle", {done, underrun, busy}, 3'b000);

    // Single 0x0001 word: line 0 rising CRC 0x1021, everything else zero (fresh CRC).
    kick(1);
    observe(1, 16'h0001, -1);
    check_block("b31", 1);
    check("b31_line0_rise", cap_r[0], 16'h1021);
    check("b31_other_crc", {cap_f[0], cap_r[1], cap_r[7], cap_f[7]}, 64'h0);

    // Start coincident with done -> START on the next cycle.
    start = 1'b1; blk_words = 8'd4;
    tick();
    start = 1'b0;
    check("b2b_start_state", {d1_wire, d2_wire, oe, busy, in_ready, done}, {16'h0000, 4'b1110});
    observe(4, 16'h1234, -1);
    check_block("b4", 4);
    tick();

    // 256-word block, with a start pulse and blk_words change mid-transfer.
    kick(0);
    observe(256, 16'hA5C3, 10);
    check_block("b256", 256);
    tick();
    check("b256_no_restart", {busy, oe}, 2'b00);

    // Reset mid-transfer, then start on the first cycle after release.
    kick(4);
    in_data = 16'h4444; tick();
    in_data = 16'h5555; tick();
    reset = 1'b1;
    tick(); tick(); tick();
    check("mid_reset_state", {d1_wire, d2_wire, oe, busy, done, underrun, in_ready},
          {16'hFFFF, 5'b00000});
    reset = 1'b0; start = 1'b1; blk_words = 8'd2;
    tick();
    start = 1'b0;
    check("post_reset_start", {oe, busy, in_ready, done, underrun}, 5'b11100);
    observe(2, 16'h0F0F, -1);
    check_block("b2", 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
